exp_pulse_gen: RTL and testbench
================================

EXP_PULSE_GEN -- requirements
Module: exp_pulse_gen

Interface
REQ-001 Parameter SIZE_ADC_DATA, default from package_settings: sample width in bits.
REQ-002 Parameter DECAY_SHIFT, default 4: decay per sample is excess >> DECAY_SHIFT.
REQ-003 Parameter BASELINE, default 0: idle output level, unsigned.
REQ-004 Parameter MAX_LEN, default 1024: maximum samples per pulse before forced return to baseline.
REQ-005 Port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-006 Port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port start, input, 1 bit: one-cycle trigger request.
REQ-008 Port amplitude, input, SIZE_ADC_DATA bits: pulse height above the current level, sampled on start.
REQ-009 Port output_data, output, SIZE_ADC_DATA bits: generated sample stream, one sample per clk, registered.
REQ-010 Port busy, output, 1 bit: high while state is not IDLE.
REQ-011 Port done, output, 1 bit: one-cycle strobe when a pulse returns to BASELINE.
REQ-012 Port pileup, output, 1 bit: one-cycle strobe when start is accepted while busy.

Function
REQ-013 States: IDLE, STEP, DECAY.
REQ-014 IDLE: output_data = BASELINE; start=1 -> STEP.
REQ-015 STEP (one cycle): output_data = min(current output_data + amplitude, 2^SIZE_ADC_DATA-1); sample counter cleared to 0; next state DECAY.
REQ-016 DECAY: excess = output_data - BASELINE; each cycle output_data <= output_data - (excess >> DECAY_SHIFT); sample counter increments by 1.
REQ-017 DECAY exit: when (excess >> DECAY_SHIFT) == 0 or sample counter reaches MAX_LEN-1, output_data <= BASELINE, done=1 that cycle, next state IDLE.
REQ-018 Latency: start sampled at edge N -> peak value visible on output_data after edge N+1; first decayed sample after edge N+2.
REQ-019 Pile-up: start=1 in DECAY -> pileup=1, transition to STEP with the current output_data as base (new amplitude added, saturated); sample counter restarts.
REQ-020 start=1 in STEP is ignored; pileup stays 0.
REQ-021 start=1 in the same cycle as a DECAY exit: the start wins; no done strobe, state STEP, pileup=1.
REQ-022 amplitude=0 on start: pulse still runs STEP then DECAY, exits on first DECAY cycle with done=1.
REQ-023 Saturation: sum width SIZE_ADC_DATA+1 internally; result clipped to all-ones, never wraps.
REQ-024 All arithmetic unsigned; output_data never below BASELINE.
REQ-025 amplitude is captured only on an accepted start; changes at other times have no effect.

Reset
REQ-026 reset=0 asynchronously forces state IDLE, output_data=BASELINE, busy=0, done=0, pileup=0, sample counter=0.
REQ-027 Reset asserted mid-pulse aborts it without a done strobe; first start after reset release starts a fresh pulse from BASELINE.

Verification
REQ-028 SIZE_ADC_DATA=12, BASELINE=0, DECAY_SHIFT=4; start with amplitude=1600 -> outputs 1600, 1500, 1407, 1320, ...; busy high throughout; done once when the value drops below 16, then output 0.
REQ-029 BASELINE=100, amplitude=4000 -> peak saturates at 4095, no wrap; decay converges to 100; done=1 exactly once.
REQ-030 Second start while output is 800, amplitude=1000 -> pileup=1 for one cycle, next output 1800, decay resumes from 1800, single done at end.
REQ-031 MAX_LEN=8, DECAY_SHIFT=8, amplitude=4000 -> forced return to BASELINE after 8 DECAY samples with done=1.
REQ-032 reset pulled low three cycles after start -> output_data=BASELINE and busy=0 immediately, no done; the next start produces a normal pulse.
REQ-033 start coinciding with a DECAY exit cycle -> no done, pileup=1, STEP taken with the new amplitude.

Source files
------------

// File: rtl/exp_pulse_gen.sv
// rtl/exp_pulse_gen.sv - exponential-decay pulse generator with pile-up handling
//
// Purpose: on a start request the output steps up by the captured amplitude
// (saturating), then decays geometrically back toward BASELINE, losing
// excess >> DECAY_SHIFT per sample. A pulse returns to BASELINE when the
// decrement reaches zero or after MAX_LEN decay samples. A start during
// decay piles up on the current level.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        asynchronous active-low reset
//   start        one-cycle trigger request
//   amplitude    pulse height above the current level, captured on an accepted start
//   output_data  registered sample stream, one sample per clk
//   busy         high while a pulse is in progress (state not IDLE)
//   done         one-cycle strobe, high in the cycle output_data returns to BASELINE
//   pileup       one-cycle strobe, high in the cycle after a start accepted during decay

package package_settings;
  localparam int SIZE_ADC_DATA = 12;
endpackage

module exp_pulse_gen #(
  parameter int          SIZE_ADC_DATA = package_settings::SIZE_ADC_DATA,
  parameter int          DECAY_SHIFT   = 4,
  parameter int unsigned BASELINE      = 0,
  parameter int          MAX_LEN       = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [SIZE_ADC_DATA-1:0] amplitude,
  output logic [SIZE_ADC_DATA-1:0] output_data,
  output logic                     busy,
  output logic                     done,
  output logic                     pileup
);

  localparam int                W        = SIZE_ADC_DATA;
  localparam int                CNT_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [W-1:0]      BASE_V   = W'(BASELINE);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    DECAY
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     data_q, data_d;
  logic [W-1:0]     amp_q, amp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             pileup_q, pileup_d;

  logic [W:0]       sum;
  logic [W-1:0]     peak;
  logic [W-1:0]     excess;
  logic [W-1:0]     dec;

  // One extra bit on the sum catches overflow so the peak clips instead of wrapping.
  assign sum    = {1'b0, data_q} + {1'b0, amp_q};
  assign peak   = sum[W] ? '1 : sum[W-1:0];

  // data_q never drops below BASE_V, so the excess never underflows.
  assign excess = data_q - BASE_V;
  assign dec    = excess >> DECAY_SHIFT;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    amp_d    = amp_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    pileup_d = 1'b0;
    case (state_q)
      IDLE: begin
        data_d = BASE_V;
        if (start) begin
          state_d = STEP;
          amp_d   = amplitude;
        end
      end
      STEP: begin
        // Base for the step is whatever level was showing when start was
        // accepted: BASELINE from idle, the held decay level on a pile-up.
        data_d  = peak;
        cnt_d   = '0;
        state_d = DECAY;
      end
      DECAY: begin
        if (start) begin
          // Start beats a simultaneous exit: level is held for the step.
          state_d  = STEP;
          amp_d    = amplitude;
          pileup_d = 1'b1;
        end else if ((dec == '0) || (cnt_q == CNT_LAST)) begin
          data_d  = BASE_V;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          data_d = data_q - dec;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        data_d  = BASE_V;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      data_q   <= BASE_V;
      amp_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      pileup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      amp_q    <= amp_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      pileup_q <= pileup_d;
    end
  end

  assign output_data = data_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign pileup      = pileup_q;

endmodule

// File: tb/tb_exp_pulse_gen.sv
// tb/tb_exp_pulse_gen.sv - scoreboard bench for exp_pulse_gen (two configurations)
module tb_exp_pulse_gen;

  localparam int W     = 12;
  localparam int MAXV  = 4095;
  localparam int SH_A  = 4;
  localparam int BS_A  = 0;
  localparam int LN_A  = 1024;
  localparam int SH_B  = 8;
  localparam int BS_B  = 100;
  localparam int LN_B  = 8;

  typedef struct {
    int val;
    bit done;
  } samp_t;

  typedef struct {
    int val;
    bit busy;
    bit done;
    bit pileup;
  } exp_t;

  typedef samp_t traj_q_t[$];
  typedef exp_t  exp_q_t[$];

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] amplitude = '0;
  logic [W-1:0] out_a, out_b;
  logic         busy_a, busy_b, done_a, done_b, pile_a, pile_b;

  exp_pulse_gen #(
    .SIZE_ADC_DATA(W), .DECAY_SHIFT(SH_A), .BASELINE(BS_A), .MAX_LEN(LN_A)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start), .amplitude(amplitude),
    .output_data(out_a), .busy(busy_a), .done(done_a), .pileup(pile_a)
  );

  exp_pulse_gen #(
    .SIZE_ADC_DATA(W), .DECAY_SHIFT(SH_B), .BASELINE(BS_B), .MAX_LEN(LN_B)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start), .amplitude(amplitude),
    .output_data(out_b), .busy(busy_b), .done(done_b), .pileup(pile_b)
  );

  always #5 clk = ~clk;

  int      checks = 0;
  int      failures = 0;
  traj_q_t traj_a, traj_b;
  exp_q_t  expq_a, expq_b;
  int      level[2];
  bit      pend[2];
  int      pend_amp[2];
  exp_t    ea, eb;

  function automatic int shift_of(input int d); return (d == 0) ? SH_A : SH_B; endfunction
  function automatic int base_of(input int d);  return (d == 0) ? BS_A : BS_B; endfunction
  function automatic int len_of(input int d);   return (d == 0) ? LN_A : LN_B; endfunction

  task automatic check(input string name, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0d expected=%0d at %0t", name, d, act, exp, $time);
    end
  endtask

  // Whole expected pulse from a given starting level: peak, decayed samples, final baseline.
  task automatic build(input int d, input int from, input int amp, ref traj_q_t tq);
    int    v, k, dec;
    samp_t t;
    tq.delete();
    v = from + amp;
    if (v > MAXV) v = MAXV;
    t.val = v; t.done = 1'b0;
    tq.push_back(t);
    k = 0;
    forever begin
      dec = (v - base_of(d)) / (1 << shift_of(d));
      if (dec == 0 || k == len_of(d) - 1) begin
        t.val = base_of(d); t.done = 1'b1;
        tq.push_back(t);
        break;
      end
      v = v - dec;
      t.val = v; t.done = 1'b0;
      tq.push_back(t);
      k++;
    end
  endtask

  task automatic model_core(input int d, input bit s, input int a, ref traj_q_t tq, ref exp_q_t eq);
    exp_t  e;
    samp_t t;
    e.val = level[d]; e.busy = 1'b0; e.done = 1'b0; e.pileup = 1'b0;
    if (pend[d]) begin
      build(d, level[d], pend_amp[d], tq);
      t = tq.pop_front();
      level[d] = t.val; e.val = t.val; e.busy = 1'b1;
      pend[d] = 1'b0;
    end else if (s) begin
      e.pileup = (tq.size() != 0);
      tq.delete();
      pend[d] = 1'b1; pend_amp[d] = a; e.busy = 1'b1;
    end else if (tq.size() != 0) begin
      t = tq.pop_front();
      level[d] = t.val; e.val = t.val; e.done = t.done; e.busy = !t.done;
    end else begin
      level[d] = base_of(d); e.val = level[d];
    end
    eq.push_back(e);
  endtask

  function automatic bit all_idle();
    return !pend[0] && !pend[1] && traj_a.size() == 0 && traj_b.size() == 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      level[d] = base_of(d); pend[d] = 1'b0; pend_amp[d] = 0;
    end
    traj_a.delete(); traj_b.delete();
  endtask

  task automatic compare(input int d, input exp_t e, input int o, input bit b, input bit dn, input bit p);
    check("output_data", d, o, e.val);
    check("busy", d, int'(b), int'(e.busy));
    check("done", d, int'(dn), int'(e.done));
    check("pileup", d, int'(p), int'(e.pileup));
  endtask

  task automatic check_reset_outputs();
    check("rst_output_data", 0, int'(out_a), BS_A);
    check("rst_busy", 0, int'(busy_a), 0);
    check("rst_done", 0, int'(done_a), 0);
    check("rst_pileup", 0, int'(pile_a), 0);
    check("rst_output_data", 1, int'(out_b), BS_B);
    check("rst_busy", 1, int'(busy_b), 0);
    check("rst_done", 1, int'(done_b), 0);
    check("rst_pileup", 1, int'(pile_b), 0);
  endtask

  // Monitor: one expected record per DUT per clock, compared away from the rising edge.
  always @(negedge clk) begin
    if (reset) begin
      if (expq_a.size() > 0) begin
        ea = expq_a.pop_front();
        compare(0, ea, int'(out_a), busy_a, done_a, pile_a);
      end
      if (expq_b.size() > 0) begin
        eb = expq_b.pop_front();
        compare(1, eb, int'(out_b), busy_b, done_b, pile_b);
      end
    end
  end

  task automatic cycle(input bit s, input int a);
    @(negedge clk);
    #1;
    start = s;
    amplitude = a[W-1:0];
    model_core(0, s, a, traj_a, expq_a);
    model_core(1, s, a, traj_b, expq_b);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (!all_idle() && n < max_cycles) begin
      cycle(1'b0, int'($urandom_range(0, MAXV)));
      n++;
    end
    if (!all_idle()) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d cycles required=idle", n);
    end
    cycle(1'b0, int'($urandom_range(0, MAXV)));
    cycle(1'b0, int'($urandom_range(0, MAXV)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    start = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int n;
    model_reset();
    #1 reset = 1'b0;
    #1 check_reset_outputs();
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;

    cycle(1'b1, 1600); drain(3000);
    cycle(1'b1, 4000); drain(3000);

    // Pile-up on a level of 800 with amplitude 1000.
    cycle(1'b1, 800); cycle(1'b0, 5); cycle(1'b1, 1000); drain(3000);

    // Start during the step cycle is ignored.
    cycle(1'b1, 500); cycle(1'b1, 3000); drain(3000);

    cycle(1'b1, 0); drain(3000);

    // Start landing exactly on the decay exit cycle.
    cycle(1'b1, 300);
    n = 0;
    while ((pend[0] || traj_a.size() != 1) && n < 3000) begin
      cycle(1'b0, int'($urandom_range(0, MAXV)));
      n++;
    end
    if (n >= 3000) begin
      checks++; failures++;
      $display("FAIL exit_align_timeout actual=%0d cycles required=exit", n);
    end
    cycle(1'b1, 700); drain(3000);

    // Reset three cycles after start aborts the pulse; next start is fresh.
    cycle(1'b1, 2000); cycle(1'b0, 1); cycle(1'b0, 2);
    do_reset();
    cycle(1'b1, 1200); drain(3000);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      cycle($urandom_range(0, 9) == 0, int'($urandom_range(0, MAXV)));
    end
    drain(3000);

    @(negedge clk);
    #1;
    check("expq_left", 0, expq_a.size(), 0);
    check("expq_left", 1, expq_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
